div_meter: RTL and testbench
============================

DIV_METER -- requirements
Module: div_meter

Interface
REQ-001 Parameter: none; all sizes fixed by shared package constants.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 penable_in  input  1  enable strobe under measurement; every high cycle counts as one event.
REQ-005 start  input  1  one-cycle request to begin a measurement.
REQ-006 ack  input  1  consumer acknowledges result; clears valid.
REQ-007 div_out  output  24  measured average event period, 16.8 fixed point (bits 23:8 integer, 7:0 fraction).
REQ-008 valid  output  1  div_out holds a completed result.
REQ-009 busy  output  1  high in ARM and MEASURE states.
REQ-010 overflow  output  1  last measurement aborted; accumulator saturated.

Function
REQ-011 States: IDLE, ARM, MEASURE, DONE; encoding from package.
REQ-012 IDLE: start=1 -> ARM; clears overflow; valid unchanged until ARM entry.
REQ-013 Entering ARM clears valid; div_out retains old value.
REQ-014 ARM: first cycle with penable_in=1 (reference event T0) -> MEASURE; accum<=0, evt_cnt<=0.
REQ-015 MEASURE: every cycle accum<=accum+1 (24 bit); penable_in=1 -> evt_cnt<=evt_cnt+1 (8 bit).
REQ-016 MEASURE: penable_in=1 with evt_cnt=255 (256th event after T0) -> div_out<=accum+1, valid<=1, -> DONE, same edge.
REQ-017 Result equals total cycles from T0 to 256th event, i.e. 256 x mean period = mean period in 16.8; no rounding, no division.
REQ-018 valid rises the cycle after the 256th event; latency from T0 = accumulated cycles + 1.
REQ-019 MEASURE: accum=0xFFFFFF without completion -> overflow<=1, valid stays 0, -> IDLE.
REQ-020 DONE: ack=1 -> valid<=0, -> IDLE; start=1 -> ARM (start wins over simultaneous ack).
REQ-021 start in ARM or MEASURE ignored; measurement continues unchanged.
REQ-022 ack while valid=0 has no effect in any state.
REQ-023 penable_in held high continuously measures 0x000100 (period 1.0).
REQ-024 penable_in never high while ARM: stays in ARM indefinitely, busy=1, no timeout.
REQ-025 busy, valid, overflow are registered outputs; no combinational path from inputs.

Reset
REQ-026 reset=0 at a clock edge: state<=IDLE, div_out<=0, valid<=0, busy<=0, overflow<=0, accum<=0, evt_cnt<=0.
REQ-027 Reset mid-MEASURE discards partial result; no valid pulse follows.
REQ-028 reset has priority over start, ack and penable_in in the same cycle.

Structure
REQ-029 Shared package holds: state enum, DIV_W=24, FRAC_W=8, EVT_W=8, NUM_EVENTS=256, ACCUM_MAX=24'hFFFFFF.
REQ-030 Single module; no sub-module; FSM, accumulator and event counter in one block.

Verification
REQ-031 Strobe period exactly 3 cycles, start -> div_out=0x000300, valid=1, overflow=0.
REQ-032 Alternating periods 2,3 (128 each) -> div_out=0x000280 (2.5).
REQ-033 penable_in constant 1 -> div_out=0x000100 after 256 cycles in MEASURE.
REQ-034 One event then none for 2^24 cycles -> overflow=1, valid=0, state IDLE, busy=0.
REQ-035 Reset low during MEASURE at event 100 -> all outputs zero; later start with period 4 -> 0x000400.
REQ-036 start and ack both high in DONE -> valid=0, busy=1 next cycle; start during MEASURE -> result unchanged.

Source files
------------

// File: rtl/div_meter_pkg.sv
// Shared constants and state encoding for the strobe period meter.
// 16.8 fixed-point result: 256 events of accumulated cycles.
package div_meter_pkg;

  localparam int DIV_W      = 24;
  localparam int FRAC_W     = 8;
  localparam int EVT_W      = 8;
  localparam int NUM_EVENTS = 256;

  localparam logic [DIV_W-1:0] ACCUM_MAX = 24'hFFFFFF;
  localparam logic [EVT_W-1:0] EVT_LAST  = EVT_W'(NUM_EVENTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_DONE
  } state_t;

endpackage

// File: rtl/div_meter.sv
// Measures the mean period of penable_in over 256 events.
// Summing 256 periods yields the mean directly in 16.8 format.
module div_meter
  import div_meter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              penable_in,
  input  logic              start,
  input  logic              ack,
  output logic [DIV_W-1:0]  div_out,
  output logic              valid,
  output logic              busy,
  output logic              overflow
);

  state_t            state;
  logic [DIV_W-1:0]  accum;
  logic [EVT_W-1:0]  evt_cnt;

  // FSM, accumulator, event counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      div_out  <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      accum    <= '0;
      evt_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ARM;
            busy     <= 1'b1;
            valid    <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_ARM: begin
          if (penable_in) begin
            state   <= S_MEASURE;
            accum   <= '0;
            evt_cnt <= '0;
          end
        end
        S_MEASURE: begin
          if (penable_in && evt_cnt == EVT_LAST) begin
            div_out <= accum + 24'd1;
            valid   <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else if (accum == ACCUM_MAX) begin
            overflow <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            accum <= accum + 24'd1;
            if (penable_in) begin
              evt_cnt <= evt_cnt + 8'd1;
            end
          end
        end
        S_DONE: begin
          // a new request takes precedence over the acknowledge
          if (start) begin
            state <= S_ARM;
            busy  <= 1'b1;
            valid <= 1'b0;
          end else if (ack) begin
            valid <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_meter.sv
// Self-checking bench for div_meter.
// Table of strobe patterns plus hand sequences for reset/overflow/DONE.
module tb_div_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        penable_in;
  logic        start;
  logic        ack;
  logic [23:0] div_out;
  logic        valid;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$];
  logic [23:0] exp_v;
  logic        seen_valid = 1'b0;

  typedef struct {
    int          pa;
    int          pb;
    bit          mid_start;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[5];

  div_meter dut (
    .clk        (clk),
    .reset      (reset),
    .penable_in (penable_in),
    .start      (start),
    .ack        (ack),
    .div_out    (div_out),
    .valid      (valid),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: compare each new result against the queued expectation
  always @(negedge clk) begin
    if (valid && !seen_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: div_out %0h, none expected",
                 div_out);
      end else begin
        exp_v = exp_q.pop_front();
        check("div_out", 32'(div_out), 32'(exp_v));
      end
    end
    seen_valid = valid;
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_arm", 32'(busy), 32'd1);
    check("valid_clr_arm", 32'(valid), 32'd0);
    repeat (3) @(negedge clk);
    check("busy_arm_wait", 32'(busy), 32'd1);
  endtask

  task automatic do_events(input int pa, input int pb, input bit mid_start,
                           input int cnt, input bit full,
                           input logic [23:0] exp);
    if (full) exp_q.push_back(exp);
    penable_in = 1'b1;
    @(negedge clk);
    penable_in = 1'b0;
    for (int k = 1; k <= cnt; k++) begin
      int p;
      p = (k % 2 == 1) ? pa : pb;
      repeat (p - 1) @(negedge clk);
      penable_in = 1'b1;
      if (mid_start && k == 50) start = 1'b1;
      @(negedge clk);
      penable_in = 1'b0;
      start = 1'b0;
    end
    if (full) begin
      check("valid_latency", 32'(valid), 32'd1);
      check("overflow_done", 32'(overflow), 32'd0);
      check("busy_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("valid_after_ack", 32'(valid), 32'd0);
    check("busy_after_ack", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{pa: 3, pb: 3, mid_start: 1'b0, exp: 24'h000300};
    vecs[1] = '{pa: 2, pb: 3, mid_start: 1'b0, exp: 24'h000280};
    vecs[2] = '{pa: 1, pb: 1, mid_start: 1'b0, exp: 24'h000100};
    vecs[3] = '{pa: 5, pb: 7, mid_start: 1'b1, exp: 24'h000600};
    vecs[4] = '{pa: 4, pb: 4, mid_start: 1'b0, exp: 24'h000400};

    reset = 1'b0;
    penable_in = 1'b0;
    start = 1'b0;
    ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_div_out", 32'(div_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("idle_ack_valid", 32'(valid), 32'd0);
    check("idle_ack_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_start();
      do_events(vecs[i].pa, vecs[i].pb, vecs[i].mid_start, 256, 1'b1,
                vecs[i].exp);
      do_ack();
    end

    do_start();
    do_events(3, 3, 1'b0, 100, 1'b0, 24'h0);
    reset = 1'b0;
    start = 1'b1;
    ack = 1'b1;
    penable_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    ack = 1'b0;
    penable_in = 1'b0;
    check("midrst_div_out", 32'(div_out), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    repeat (20) @(negedge clk);
    check("midrst_no_valid", 32'(valid), 32'd0);
    do_start();
    do_events(4, 4, 1'b0, 256, 1'b1, 24'h000400);
    do_ack();

    do_start();
    do_events(2, 2, 1'b0, 256, 1'b1, 24'h000200);
    start = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    check("done_start_ack_valid", 32'(valid), 32'd0);
    check("done_start_ack_busy", 32'(busy), 32'd1);
    check("done_start_ack_div", 32'(div_out), 32'h000200);
    do_events(3, 3, 1'b0, 256, 1'b1, 24'h000300);
    do_ack();

    do_start();
    repeat (50) @(negedge clk);
    check("arm_no_timeout", 32'(busy), 32'd1);
    penable_in = 1'b1;
    @(negedge clk);
    penable_in = 1'b0;
    repeat (3) @(negedge clk);
    force dut.accum = 24'hFFFFF0;
    @(posedge clk);
    #1 release dut.accum;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
        @(negedge clk);
        got = overflow;
      end
    end
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_valid", 32'(valid), 32'd0);
    check("ovf_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("ovf_idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ovf_clr_on_start", 32'(overflow), 32'd0);
    check("ovf_restart_busy", 32'(busy), 32'd1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
